// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master
//
// Load/store initiator between the execute stage and a word-wide data memory.
// It takes one load/store request at a time and drives the memory port.
// Loads get byte/halfword lane extraction and sign/zero extension.
// Sub-word stores (SB/SH) are done as a read-modify-write of the containing word.
// Misaligned, out-of-range and illegal requests are answered with an error.
// Such requests never touch memory.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_we, req_funct3    store/load select and RISC-V size/sign code
//   req_addr, req_wdata   byte address and right-aligned store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  extended load data (0 for stores/errors), error flag
//   MemRead, MemWrite     memory enables (never both high)
//   address, write_data   word index and write word to memory
//   read_data             combinational memory read data

module lsu_dmem_master #(
    parameter int DEPTH_WORDS = 256,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            MemRead,
    output logic            MemWrite,
    output logic [XLEN-1:0] address,
    output logic [XLEN-1:0] write_data,
    input  logic [XLEN-1:0] read_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    localparam logic [XLEN-3:0] WORD_LIMIT = (XLEN-2)'(DEPTH_WORDS);

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] merge_q;
    logic [XLEN-1:0] rdata_q;
    logic [2:0]      funct3_q;
    logic            we_q;
    logic            err_q;
    logic            accept;

    // A request is bad if its code is illegal for the direction,
    // if it is misaligned for its size, or if it lies beyond the memory.
    // funct3[1:0] gives the size for every legal code (00 byte, 01 half, 10 word).
    function automatic logic isBad(input logic we, input logic [2:0] f3,
                                   input logic [XLEN-1:0] a);
        logic illegal;
        logic mis;
        logic oor;
        case (f3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = we;
            default:                illegal = 1'b1;
        endcase
        mis = ((f3[1:0] == 2'b01) && a[0]) ||
              ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
        oor = (a[XLEN-1:2] >= WORD_LIMIT);
        return illegal || mis || oor;
    endfunction

    // Pick the addressed lane out of the word and extend it according to funct3.
    function automatic logic [XLEN-1:0] loadExtend(input logic [XLEN-1:0] word,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] off);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Replace only the target byte/halfword lane of the fetched word with store data.
    function automatic logic [XLEN-1:0] storeMerge(input logic [XLEN-1:0] word,
                                                   input logic [XLEN-1:0] wd,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] off);
        logic [XLEN-1:0] r;
        r = word;
        if (f3[1:0] == 2'b00) begin
            r[{off, 3'b000} +: 8] = wd[7:0];
        end else begin
            r[{off[1], 4'b0000} +: 16] = wd[15:0];
        end
        return r;
    endfunction

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

    // Next-state selection; the request is classified only at the accept edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (isBad(req_we, req_funct3, req_addr)) begin
                        state_d = S_ERR;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD:   state_d = S_RESP;
            S_WRITE:  state_d = S_RESP;
            S_RMW_RD: state_d = S_RMW_WR;
            S_RMW_WR: state_d = S_RESP;
            S_ERR:    state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State plus latched request. The result and error flag are cleared on accept.
    // They then hold their value until the next request, so they are stable
    // during the response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                funct3_q <= req_funct3;
                we_q     <= req_we;
                rdata_q  <= '0;
                err_q    <= 1'b0;
            end
            if (state_q == S_LOAD) begin
                rdata_q <= loadExtend(read_data, funct3_q, addr_q[1:0]);
            end
            if (state_q == S_RMW_RD) begin
                merge_q <= read_data;
            end
            if (state_q == S_ERR) begin
                err_q <= 1'b1;
            end
        end
    end

    // Memory-side outputs come from state and latched registers only.
    // This keeps req_* off any path to the memory port.
    always_comb begin
        MemRead    = (state_q == S_LOAD) || (state_q == S_RMW_RD);
        MemWrite   = ((state_q == S_WRITE) || (state_q == S_RMW_WR)) && we_q;
        address    = {2'b00, addr_q[XLEN-1:2]};
        write_data = '0;
        if (state_q == S_WRITE) begin
            write_data = wdata_q;
        end else if (state_q == S_RMW_WR) begin
            write_data = storeMerge(merge_q, wdata_q, funct3_q, addr_q[1:0]);
        end
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
